// File: rtl/sdram_bank_model.sv
// Behavioural SDRAM model: per-bank row state, mode register, burst read/write engine and
// CAS-latency read pipeline. Define SDRAM_MODEL_TRCD_EN to enable the ACTIVE-to-READ/WRITE check.
module sdram_bank_model #(
    parameter int unsigned DQ_W         = 16,
    parameter int unsigned ROW_W        = 13,
    parameter int unsigned COL_W        = 10,
    parameter int unsigned BA_W         = 2,
    parameter int unsigned MEM_ROW_BITS = 4,
    parameter int unsigned CL_DEFAULT   = 2,
    parameter int unsigned BL_DEFAULT   = 1,
    parameter int unsigned TRCD         = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cke,
    input  logic             cs_n,
    input  logic             ras_n,
    input  logic             cas_n,
    input  logic             we_n,
    input  logic [BA_W-1:0]  ba,
    input  logic [ROW_W-1:0] addr,
    input  logic             ldqm,
    input  logic             udqm,
    inout  wire  [DQ_W-1:0]  dq,
    output logic             err,
    output logic             rd_valid
);

    localparam int unsigned NB        = 2 ** BA_W;
    localparam int unsigned MEM_AW    = BA_W + MEM_ROW_BITS + COL_W;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;
    localparam logic [1:0]  BL_LOG_DEF = (BL_DEFAULT == 8) ? 2'd3 :
                                         (BL_DEFAULT == 4) ? 2'd2 :
                                         (BL_DEFAULT == 2) ? 2'd1 : 2'd0;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_BST
    } cmd_e;

    typedef enum logic [1:0] {BST_IDLE, BST_READ, BST_WRITE} bst_e;

    logic [DQ_W-1:0]         mem [MEM_DEPTH];
    logic [NB-1:0]           bank_act;
    logic [ROW_W-1:0]        bank_row [NB];
    logic [1:0]              cl;
    logic [1:0]              bl_log;

    bst_e                    bst_state;
    logic [BA_W-1:0]         bst_bank;
    logic [MEM_ROW_BITS-1:0] bst_row;
    logic [COL_W-1:0]        bst_col;
    logic [2:0]              bst_cnt;
    logic [1:0]              bst_bl;
    logic                    bst_ap;

    logic [DQ_W-1:0]         pipe_d [3];
    logic [2:0]              pipe_v;
    logic [DQ_W-1:0]         out_d;

    cmd_e                    cmd_c;
    logic                    rcd_ok_c, rw_ok_c, mrs_ok_c, cmd_err_c, end_c;
    logic                    iss_c, iss_wr_c, iss_last_c, iss_ap_c, rd_new_v_c;
    logic [BA_W-1:0]         iss_bank_c;
    logic [MEM_ROW_BITS-1:0] iss_row_c;
    logic [COL_W-1:0]        iss_col_c, bl_mask_c;
    logic [MEM_AW-1:0]       iss_addr_c;
    logic [DQ_W-1:0]         rd_new_d_c;

`ifdef SDRAM_MODEL_TRCD_EN
    // Cycles since ACTIVE per bank, saturating at TRCD
    logic [3:0] rcd_cnt [NB];

    assign rcd_ok_c = rcd_cnt[ba] >= 4'(TRCD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NB); i++) rcd_cnt[i] <= 4'(TRCD);
        end else if (cke) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (cmd_c == CMD_ACT && !bank_act[ba] && ba == BA_W'(i))
                    rcd_cnt[i] <= 4'd1;
                else if (rcd_cnt[i] < 4'(TRCD))
                    rcd_cnt[i] <= rcd_cnt[i] + 4'd1;
            end
        end
    end
`else
    assign rcd_ok_c = 1'b1;
`endif

    // Command decode, protocol checks and the beat issued on this edge
    always_comb begin
        cmd_c = CMD_NOP;
        if (cke && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd_c = CMD_ACT;
                3'b101:  cmd_c = CMD_RD;
                3'b100:  cmd_c = CMD_WR;
                3'b010:  cmd_c = CMD_PRE;
                3'b001:  cmd_c = CMD_REF;
                3'b000:  cmd_c = CMD_MRS;
                3'b110:  cmd_c = CMD_BST;
                default: cmd_c = CMD_NOP;
            endcase
        end

        mrs_ok_c = (addr[2:0] <= 3'd3) && (addr[6:4] == 3'd2 || addr[6:4] == 3'd3);
        rw_ok_c  = (cmd_c == CMD_RD || cmd_c == CMD_WR) && bank_act[ba] && rcd_ok_c;

        cmd_err_c = 1'b0;
        case (cmd_c)
            CMD_ACT: cmd_err_c = bank_act[ba];
            CMD_RD,
            CMD_WR:  cmd_err_c = !rw_ok_c;
            CMD_REF: cmd_err_c = |bank_act;
            CMD_MRS: cmd_err_c = (|bank_act) || !mrs_ok_c;
            default: cmd_err_c = 1'b0;
        endcase

        end_c = rw_ok_c || cmd_c == CMD_BST ||
                (cmd_c == CMD_PRE && (addr[10] || ba == bst_bank));

        // Continuing burst: sequential wrap inside the aligned BL block
        bl_mask_c  = (COL_W'(1) << bst_bl) - COL_W'(1);
        iss_c      = cke && (bst_state != BST_IDLE) && !end_c;
        iss_wr_c   = bst_state == BST_WRITE;
        iss_bank_c = bst_bank;
        iss_row_c  = bst_row;
        iss_col_c  = (bst_col & ~bl_mask_c) | ((bst_col + COL_W'(bst_cnt)) & bl_mask_c);
        iss_last_c = bst_cnt == 3'((4'd1 << bst_bl) - 4'd1);
        iss_ap_c   = bst_ap;

        if (rw_ok_c) begin
            iss_c      = 1'b1;
            iss_wr_c   = cmd_c == CMD_WR;
            iss_bank_c = ba;
            iss_row_c  = bank_row[ba][MEM_ROW_BITS-1:0];
            iss_col_c  = addr[COL_W-1:0];
            iss_last_c = bl_log == 2'd0;
            iss_ap_c   = addr[10];
        end

        iss_addr_c = {iss_bank_c, iss_row_c, iss_col_c};
        rd_new_v_c = iss_c && !iss_wr_c;
        rd_new_d_c = mem[iss_addr_c];
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (iss_c && iss_wr_c) begin
            if (!ldqm) mem[iss_addr_c][7:0]      <= dq[7:0];
            if (!udqm) mem[iss_addr_c][DQ_W-1:8] <= dq[DQ_W-1:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_act  <= '0;
            for (int i = 0; i < int'(NB); i++) bank_row[i] <= '0;
            cl        <= 2'(CL_DEFAULT);
            bl_log    <= BL_LOG_DEF;
            bst_state <= BST_IDLE;
            bst_bank  <= '0;
            bst_row   <= '0;
            bst_col   <= '0;
            bst_cnt   <= '0;
            bst_bl    <= '0;
            bst_ap    <= 1'b0;
            pipe_v    <= '0;
            for (int i = 0; i < 3; i++) pipe_d[i] <= '0;
            rd_valid  <= 1'b0;
            out_d     <= '0;
            err       <= 1'b0;
        end else if (cke) begin
            if (cmd_err_c) err <= 1'b1;

            case (cmd_c)
                CMD_ACT: if (!bank_act[ba]) begin
                    bank_act[ba] <= 1'b1;
                    bank_row[ba] <= addr;
                end
                CMD_PRE: if (addr[10]) bank_act <= '0;
                         else          bank_act[ba] <= 1'b0;
                CMD_MRS: if (!cmd_err_c) begin
                    bl_log <= addr[1:0];
                    cl     <= addr[5:4];
                end
                default: ;
            endcase

            if (iss_c && iss_last_c && iss_ap_c) bank_act[iss_bank_c] <= 1'b0;

            // Burst engine
            if (rw_ok_c) begin
                if (bl_log == 2'd0)        bst_state <= BST_IDLE;
                else if (cmd_c == CMD_WR)  bst_state <= BST_WRITE;
                else                       bst_state <= BST_READ;
                bst_bank <= ba;
                bst_row  <= bank_row[ba][MEM_ROW_BITS-1:0];
                bst_col  <= addr[COL_W-1:0];
                bst_cnt  <= 3'd1;
                bst_bl   <= bl_log;
                bst_ap   <= addr[10];
            end else if (end_c) begin
                bst_state <= BST_IDLE;
            end else if (iss_c) begin
                if (iss_last_c) bst_state <= BST_IDLE;
                else            bst_cnt   <= bst_cnt + 3'd1;
            end

            // Read beats enter the pipeline at a depth that depends on CL
            if (cmd_c == CMD_WR && rw_ok_c) begin
                pipe_v   <= '0;
                rd_valid <= 1'b0;
            end else begin
                pipe_v[0] <= rd_new_v_c && cl == 2'd3;
                pipe_d[0] <= rd_new_d_c;
                pipe_v[1] <= (cl == 2'd3) ? pipe_v[0] : rd_new_v_c;
                pipe_d[1] <= (cl == 2'd3) ? pipe_d[0] : rd_new_d_c;
                pipe_v[2] <= pipe_v[1];
                pipe_d[2] <= pipe_d[1];
                rd_valid  <= pipe_v[2];
                out_d     <= pipe_d[2];
            end
        end
    end

    assign dq = rd_valid ? out_d : {DQ_W{1'bz}};

endmodule
